// File: rtl/mipi_csi_pkt_decoder.sv
// CSI-2 long-packet decoder: locks on the lane sync word, parses the packet header
// and forwards payload words tagged with a packet-type code.
// Optional feature macro: CSI_PACKET_LENGTH_OUT_EN (adds packet_length_o).
module mipi_csi_pkt_decoder (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        output_valid_o,
    output logic [31:0] data_o,
    output logic [2:0]  packet_type_o
`ifdef CSI_PACKET_LENGTH_OUT_EN
    ,
    output logic [15:0] packet_length_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    localparam logic [31:0] SYNC_WORD = 32'hB8B8B8B8;

    function automatic logic [2:0] type_code(input logic [7:0] dt);
        case (dt)
            8'h2A:   type_code = 3'd1;
            8'h2B:   type_code = 3'd2;
            8'h2C:   type_code = 3'd3;
            8'h2D:   type_code = 3'd4;
            8'h1E:   type_code = 3'd5;
            8'h24:   type_code = 3'd6;
            default: type_code = 3'd7;
        endcase
    endfunction

    state_t      r_state, w_state_nxt;
    logic [15:0] r_remaining, w_remaining_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic [2:0]  r_type, w_type_nxt;
    logic [7:0]  w_dt;
    logic [15:0] w_wc;
    logic        w_long_ok;

    assign w_dt      = data_i[7:0];
    assign w_wc      = data_i[23:8];
    // Short packets (DT below 0x10) and empty long packets carry nothing to forward.
    assign w_long_ok = (w_dt >= 8'h10) && (w_wc != 16'd0);

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_remaining <= 16'd0;
            r_valid     <= 1'b0;
            r_data      <= 32'd0;
            r_type      <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_valid     <= w_valid_nxt;
            r_data      <= w_data_nxt;
            r_type      <= w_type_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_valid_nxt     = 1'b0;
        w_data_nxt      = r_data;
        w_type_nxt      = r_type;
        case (r_state)
            ST_IDLE: begin
                if (data_valid_i && (data_i == SYNC_WORD)) begin
                    w_state_nxt = ST_HEADER;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (!data_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_long_ok) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_remaining_nxt = w_wc;
                    w_type_nxt      = type_code(w_dt);
                    w_state_nxt     = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!data_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_data_nxt  = data_i;
                    w_valid_nxt = 1'b1;
                    // Compare before subtracting so the counter never wraps.
                    if (r_remaining <= 16'd4) begin
                        w_remaining_nxt = 16'd0;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_remaining_nxt = r_remaining - 16'd4;
                        w_state_nxt     = ST_PAYLOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign output_valid_o = r_valid;
    assign data_o         = r_data;
    assign packet_type_o  = r_type;

`ifdef CSI_PACKET_LENGTH_OUT_EN
    logic [15:0] r_length, w_length_nxt;

    // Word count captured on the same header edge as the type code.
    always_comb begin
        w_length_nxt = r_length;
        if ((r_state == ST_HEADER) && data_valid_i && w_long_ok) begin
            w_length_nxt = w_wc;
        end else begin
            w_length_nxt = r_length;
        end
    end

    // Packet length register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_length <= 16'd0;
        end else begin
            r_length <= w_length_nxt;
        end
    end

    assign packet_length_o = r_length;
`else
    // Packet length is not tracked in this build.
`endif

endmodule

// File: tb/tb_mipi_csi_pkt_decoder.sv
// Directed self-checking bench for mipi_csi_pkt_decoder.
// Honours CSI_PACKET_LENGTH_OUT_EN when defined.
module tb_mipi_csi_pkt_decoder;

    logic        clk_i;
    logic        reset_n_i;
    logic        data_valid_i;
    logic [31:0] data_i;
    logic        output_valid_o;
    logic [31:0] data_o;
    logic [2:0]  packet_type_o;
`ifdef CSI_PACKET_LENGTH_OUT_EN
    logic [15:0] packet_length_o;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] cap[$];
    int          base;

    mipi_csi_pkt_decoder dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .output_valid_o (output_valid_o),
        .data_o         (data_o),
        .packet_type_o  (packet_type_o)
`ifdef CSI_PACKET_LENGTH_OUT_EN
        ,
        .packet_length_o(packet_length_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Capture every forwarded payload word, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1 && output_valid_o === 1'b1) cap.push_back(data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one word, let one rising edge pass, return 1 time unit later.
    task automatic send(input logic v, input logic [31:0] d);
        data_valid_i = v;
        data_i       = d;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_n_i    = 1'b0;
        data_valid_i = 1'b0;
        data_i       = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", {31'd0, output_valid_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_type", {29'd0, packet_type_o}, 32'd0);
`ifdef CSI_PACKET_LENGTH_OUT_EN
        check("rst_len", {16'd0, packet_length_o}, 32'd0);
`endif
        reset_n_i = 1'b1;
        send(1'b0, 32'd0);

        // Short packet: frame start, then data that must be ignored.
        base = cap.size();
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'h00000000);
        for (int k = 0; k < 4; k++) send(1'b1, 32'h11111111 * 32'(k + 1));
        // Long DT with WC=0 is also dropped.
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'h0000002A);
        for (int k = 0; k < 3; k++) send(1'b1, 32'h22222222);
        // Misaligned sync word is not a lock.
        send(1'b1, 32'hB8B8B800);
        send(1'b1, 32'h0018002A);
        for (int k = 0; k < 6; k++) send(1'b1, 32'h33333333);
        send(1'b0, 32'd0);
        check("short_cnt", 32'(cap.size() - base), 32'd0);
        check("short_type", {29'd0, packet_type_o}, 32'd0);

        // RAW10 frame, WC=2400 -> 600 words.
        base = cap.size();
        send(1'b1, 32'h00000000);
        send(1'b1, 32'h00000000);
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'hAB09602B);
        check("raw10_type_hdr", {29'd0, packet_type_o}, 32'd2);
        check("raw10_nolat", {31'd0, output_valid_o}, 32'd0);
`ifdef CSI_PACKET_LENGTH_OUT_EN
        check("raw10_len", {16'd0, packet_length_o}, 32'd2400);
`endif
        for (int k = 0; k < 608; k++) begin
            send(1'b1, 32'(k * 40000));
            if (k == 0) begin
                check("raw10_lat_v", {31'd0, output_valid_o}, 32'd1);
                check("raw10_lat_d", data_o, 32'd0);
            end
        end
        check("raw10_fall", {31'd0, output_valid_o}, 32'd0);
        send(1'b0, 32'd0);
        check("raw10_cnt", 32'(cap.size() - base), 32'd600);
        check("raw10_type", {29'd0, packet_type_o}, 32'd2);
        if (cap.size() - base >= 600) begin
            check("raw10_w0", cap[base], 32'h00000000);
            check("raw10_w1", cap[base + 1], 32'h00009C40);
            check("raw10_wlast", cap[base + 599], 32'h016D99C0);
        end else begin
            check("raw10_words_present", 32'(cap.size() - base), 32'd600);
        end

        // Abort after 10 words of a WC=400 RAW12 packet.
        base = cap.size();
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'h0001902C);
        for (int k = 0; k < 10; k++) send(1'b1, 32'h0A000000 + 32'(k));
        check("abort_v_last", {31'd0, output_valid_o}, 32'd1);
        send(1'b0, 32'd0);
        check("abort_v_drop", {31'd0, output_valid_o}, 32'd0);
        for (int k = 0; k < 5; k++) send(1'b1, 32'h0B000000 + 32'(k));
        check("abort_cnt", 32'(cap.size() - base), 32'd10);
        check("abort_type", {29'd0, packet_type_o}, 32'd3);

        // Restart with YUV422 WC=8; a sync word inside payload is data.
        base = cap.size();
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'h0000081E);
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'hCAFEF00D);
        send(1'b1, 32'hDEADBEEF);
        send(1'b0, 32'd0);
        check("yuv_cnt", 32'(cap.size() - base), 32'd2);
        check("yuv_type", {29'd0, packet_type_o}, 32'd5);
        if (cap.size() - base >= 2) begin
            check("yuv_w0", cap[base], 32'hB8B8B8B8);
            check("yuv_w1", cap[base + 1], 32'hCAFEF00D);
        end else begin
            check("yuv_words_present", 32'(cap.size() - base), 32'd2);
        end

        // Odd length: RAW8 WC=6 -> 2 words.
        base = cap.size();
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'h0000062A);
        send(1'b1, 32'h44332211);
        send(1'b1, 32'h88776655);
        send(1'b1, 32'h99999999);
        send(1'b0, 32'd0);
        check("odd_cnt", 32'(cap.size() - base), 32'd2);
        check("odd_type", {29'd0, packet_type_o}, 32'd1);
        check("odd_last", data_o, 32'h88776655);
`ifdef CSI_PACKET_LENGTH_OUT_EN
        check("odd_len", {16'd0, packet_length_o}, 32'd6);
`endif

        // RGB888 then unknown long DT 0x30.
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'h00000424);
        check("rgb_type", {29'd0, packet_type_o}, 32'd6);
        send(1'b1, 32'h01020304);
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'h00000430);
        check("other_type", {29'd0, packet_type_o}, 32'd7);
        send(1'b1, 32'h05060708);
        check("other_data", data_o, 32'h05060708);
        send(1'b0, 32'd0);

        // Reset mid-packet drops it; no output until a new sync word.
        base = cap.size();
        send(1'b1, 32'hB8B8B8B8);
        send(1'b1, 32'h0010002B);
        send(1'b1, 32'h12345678);
        send(1'b1, 32'h9ABCDEF0);
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, output_valid_o}, 32'd0);
        check("mid_rst_data", data_o, 32'd0);
        check("mid_rst_type", {29'd0, packet_type_o}, 32'd0);
        base = cap.size();
        send(1'b1, 32'h11112222);
        reset_n_i = 1'b1;
        for (int k = 0; k < 4; k++) send(1'b1, 32'h55550000 + 32'(k));
        send(1'b0, 32'd0);
        check("post_rst_cnt", 32'(cap.size() - base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
